fp_nan_scan: RTL

Pipelined, multi-lane IEEE-754 operand classifier with valid/ready flow control. It classifies every lane of an incoming vector into six classes, optionally quiets signaling NaNs on the data path, and keeps a sticky invalid-operation flag plus a saturating SNaN counter. It sits in front of the FP min/max and compare datapaths, replacing per-operand NaN checks with one shared, backpressure-aware stage.

---
 rtl/fp_class_pkg.sv | 34 +++
 rtl/fp_class_lane.sv | 59 +++++
 rtl/fp_nan_scan.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fp_class_pkg.sv
// ----------------------------------------------------------------------------
// fp_class_pkg
// Shared types for the FP operand classifier: the 3-bit class code, default
// widths for the classifier parameters, and small class predicates.
// ----------------------------------------------------------------------------
package fp_class_pkg;

  localparam int unsigned CLASS_W    = 3;
  localparam int unsigned DEF_EXPO_W = 8;
  localparam int unsigned DEF_MANT_W = 23;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  // Class codes; 6 and 7 are never produced.
  typedef enum logic [CLASS_W-1:0] {
    FPC_ZERO = 3'd0,
    FPC_SUB  = 3'd1,
    FPC_NORM = 3'd2,
    FPC_INF  = 3'd3,
    FPC_QNAN = 3'd4,
    FPC_SNAN = 3'd5
  } fp_class_e;

  // True for either NaN flavour.
  function automatic logic fp_is_nan(input fp_class_e c);
    return (c == FPC_QNAN) || (c == FPC_SNAN);
  endfunction

  // True only for signaling NaN.
  function automatic logic fp_is_snan(input fp_class_e c);
    return (c == FPC_SNAN);
  endfunction

endpackage

// File: rtl/fp_class_lane.sv
// ----------------------------------------------------------------------------
// fp_class_lane
// Combinational single-operand classifier. Produces the class code and the
// operand with its quiet bit forced when it is an SNaN and quieting is enabled.
//
// Ports:
//   i_op      in  FP_W  operand {sign, exponent, mantissa}
//   i_qen     in  1     quiet signaling NaNs
//   o_class_c out 3     class code (fp_class_e)
//   o_data_c  out FP_W  operand, quieted if SNaN and i_qen
// ----------------------------------------------------------------------------
module fp_class_lane
  import fp_class_pkg::*;
#(
  parameter int unsigned EXPO_W = DEF_EXPO_W,
  parameter int unsigned MANT_W = DEF_MANT_W
) (
  input  logic [EXPO_W+MANT_W:0] i_op,
  input  logic                   i_qen,
  output fp_class_e              o_class_c,
  output logic [EXPO_W+MANT_W:0] o_data_c
);

  localparam int unsigned FP_W = 1 + EXPO_W + MANT_W;
  // Quiet bit is the mantissa MSB.
  localparam logic [FP_W-1:0] QBIT_MASK = FP_W'(1) << (MANT_W - 1);

  logic [EXPO_W-1:0] w_expo;
  logic [MANT_W-1:0] w_mant;
  logic              w_expo_zero;
  logic              w_expo_ones;
  logic              w_mant_zero;

  assign w_expo      = i_op[MANT_W +: EXPO_W];
  assign w_mant      = i_op[MANT_W-1:0];
  assign w_expo_zero = ~|w_expo;
  assign w_expo_ones = &w_expo;
  assign w_mant_zero = ~|w_mant;

  // Class decode from exponent/mantissa fields.
  always_comb begin
    o_class_c = FPC_NORM;
    if (w_expo_zero) begin
      o_class_c = w_mant_zero ? FPC_ZERO : FPC_SUB;
    end else if (w_expo_ones) begin
      if (w_mant_zero) begin
        o_class_c = FPC_INF;
      end else if (w_mant[MANT_W-1]) begin
        o_class_c = FPC_QNAN;
      end else begin
        o_class_c = FPC_SNAN;
      end
    end
  end

  // Only the quiet bit changes; sign and payload pass through.
  assign o_data_c = (i_qen && (o_class_c == FPC_SNAN)) ? (i_op | QBIT_MASK) : i_op;

endmodule

// File: rtl/fp_nan_scan.sv
// ----------------------------------------------------------------------------
// fp_nan_scan
// Two-stage, multi-lane IEEE-754 operand classifier with valid/ready flow
// control, optional SNaN quieting, a sticky invalid flag and a saturating
// SNaN lane counter.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready independent of in_valid)
//   in_data             LANES operands, lane i at [i*FP_W +: FP_W]
//   quiet_en            quiet SNaN lanes of this beat
//   clr_sticky          synchronous clear of sticky_nv / snan_cnt
//   out_valid/out_ready output handshake
//   out_data            data, quieted where requested
//   out_class           per-lane 3-bit class code
//   out_any_nan         any lane QNaN or SNaN
//   out_any_snan        any lane SNaN
//   sticky_nv           SNaN accepted since last clear/reset
//   snan_cnt            saturating count of accepted SNaN lanes
// ----------------------------------------------------------------------------
module fp_nan_scan
  import fp_class_pkg::*;
#(
  parameter int unsigned EXPO_W = DEF_EXPO_W,
  parameter int unsigned MANT_W = DEF_MANT_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*(1+EXPO_W+MANT_W)-1:0]     in_data,
  input  logic                                   quiet_en,
  input  logic                                   clr_sticky,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*(1+EXPO_W+MANT_W)-1:0]     out_data,
  output logic [LANES*CLASS_W-1:0]               out_class,
  output logic                                   out_any_nan,
  output logic                                   out_any_snan,
  output logic                                   sticky_nv,
  output logic [CNT_W-1:0]                       snan_cnt
);

  localparam int unsigned FP_W  = 1 + EXPO_W + MANT_W;
  localparam int unsigned PC_W  = $clog2(LANES + 1);
  // Sum width covers both operands plus a carry so overflow is visible.
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Lane classification of the incoming beat
  fp_class_e         w_in_class [LANES];
  logic [FP_W-1:0]   w_in_data  [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_class_lane #(
      .EXPO_W (EXPO_W),
      .MANT_W (MANT_W)
    ) u_lane (
      .i_op      (in_data[g*FP_W +: FP_W]),
      .i_qen     (quiet_en),
      .o_class_c (w_in_class[g]),
      .o_data_c  (w_in_data[g])
    );
  end

  // Handshake: S2 advances when empty or drained; S1 follows S2.
  logic w_s2_adv;
  logic w_in_acc;
  logic r_s1_valid;

  assign w_s2_adv = !out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_in_acc = in_valid && in_ready;

  // Stage 1: data (quiet_en already applied by the lane) and classes
  logic [FP_W-1:0] r_s1_data  [LANES];
  fp_class_e       r_s1_class [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_data[i]  <= '0;
        r_s1_class[i] <= FPC_ZERO;
      end
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_acc) begin
        for (int i = 0; i < LANES; i++) begin
          r_s1_data[i]  <= w_in_data[i];
          r_s1_class[i] <= w_in_class[i];
        end
      end
    end
  end

  // Any-NaN / any-SNaN reductions over the S1 classes
  logic w_s1_any_nan;
  logic w_s1_any_snan;

  always_comb begin
    w_s1_any_nan  = 1'b0;
    w_s1_any_snan = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_s1_any_nan  = w_s1_any_nan  | fp_is_nan(r_s1_class[i]);
      w_s1_any_snan = w_s1_any_snan | fp_is_snan(r_s1_class[i]);
    end
  end

  // Stage 2: output registers, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_class    <= '0;
      out_any_nan  <= 1'b0;
      out_any_snan <= 1'b0;
    end else if (w_s2_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          out_data[i*FP_W +: FP_W]       <= r_s1_data[i];
          out_class[i*CLASS_W +: CLASS_W] <= r_s1_class[i];
        end
        out_any_nan  <= w_s1_any_nan;
        out_any_snan <= w_s1_any_snan;
      end
    end
  end

  // SNaN lanes in the incoming beat
  logic [PC_W-1:0] w_snan_pc;

  always_comb begin
    w_snan_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      w_snan_pc = w_snan_pc + PC_W'(fp_is_snan(w_in_class[i]));
    end
  end

  // Saturating add; a same-cycle clear zeroes the base before the new beat.
  logic [CNT_W-1:0] w_cnt_base;
  logic [SUM_W-1:0] w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_cnt_base = clr_sticky ? '0 : snan_cnt;
  assign w_cnt_sum  = SUM_W'(w_cnt_base) + SUM_W'(w_snan_pc);
  assign w_cnt_next = (w_cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(w_cnt_sum);

  // Statistics update on acceptance or on a lone clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_nv <= 1'b0;
      snan_cnt  <= '0;
    end else if (w_in_acc) begin
      snan_cnt  <= w_cnt_next;
      sticky_nv <= (sticky_nv && !clr_sticky) || (w_snan_pc != '0);
    end else if (clr_sticky) begin
      snan_cnt  <= '0;
      sticky_nv <= 1'b0;
    end
  end

endmodule
